// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel push-button debouncer.
// Each channel passes through a 2-flop synchroniser and a stable-time filter.
// The filter produces a clean level and one-cycle press/release pulses.
// any_press is a registered OR of the press pulses, one cycle late.
// Optional auto-repeat of press_pulse while a button is held is enabled by
// defining DEBOUNCE_REPEAT_EN.
module debounce_bank #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned COUNT_MAX    = 1000000,
    parameter int unsigned REPEAT_COUNT = 25000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_press
);

    localparam int unsigned CNT_W = $clog2(COUNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

    // Elaboration-time sanity check on the configuration
    if (CHANNELS < 1 || COUNT_MAX < 2 || REPEAT_COUNT < 2) begin : g_bad_param
        $error("debounce_bank: CHANNELS>=1, COUNT_MAX>=2, REPEAT_COUNT>=2 required");
    end

    logic [CHANNELS-1:0] s1_q, s2_q;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic                any_q;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned RCNT_W = $clog2(REPEAT_COUNT);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_COUNT - 1);

    logic [RCNT_W-1:0] rcnt_q [CHANNELS];
    logic [RCNT_W-1:0] rcnt_d [CHANNELS];
`endif

    // Stable-time filter and pulse generation, per channel
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == level_q[i]) begin
                // Any return to the current level restarts the filter
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_LAST) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i]     = '0;
                level_d[i]   = s2_q[i];
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end
`ifdef DEBOUNCE_REPEAT_EN
            rcnt_d[i] = rcnt_q[i];
            if (!level_q[i]) begin
                rcnt_d[i] = '0;
            end else if (s2_q[i]) begin
                if (rcnt_q[i] == RCNT_LAST) begin
                    rcnt_d[i]  = '0;
                    press_d[i] = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
                end
            end
            // s2 low while level high: release filtering, repeat count held
`endif
        end
    end

    // State registers: synchroniser, filter counters, level and pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
                rcnt_q[i] <= '0;
`endif
            end
        end else begin
            s1_q      <= button;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= |press_q;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
`ifdef DEBOUNCE_REPEAT_EN
                rcnt_q[i] <= rcnt_d[i];
`endif
            end
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign any_press     = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: scoreboard bench for debounce_bank (CHANNELS=4,
// COUNT_MAX=4, REPEAT_COUNT=8). A reference model predicts the outputs after
// every clock edge and queues them; a monitor pops and compares each cycle.
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int CM = 4;
    localparam int RC = 8;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] button  = '0;
    logic [CH-1:0] level, press_pulse, release_pulse;
    logic          any_press;

    debounce_bank #(
        .CHANNELS    (CH),
        .COUNT_MAX   (CM),
        .REPEAT_COUNT(RC)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .button       (button),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_press    (any_press)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] prs;
        logic [CH-1:0] rls;
        logic          anyp;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: button samples since reset (with the two
    // synchroniser zeros in front), accepted level, held-cycle counter.
    bit   raw[CH][$];
    bit   m_level[CH];
    int   m_rc[CH];
    bit   m_prev_any;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            raw[c] = {};
            raw[c].push_back(1'b0);
            raw[c].push_back(1'b0);
            m_level[c] = 1'b0;
            m_rc[c]    = 0;
        end
        m_prev_any = 1'b0;
    endfunction

    // Model: a level flips once the filtered input has differed from it on
    // COUNT_MAX consecutive edges; that input lags the pin by two edges.
    always @(posedge clock) begin
        obs_t e;
        int   n;
        bit   s2, all_diff, lvl_before;
        e = '0;
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                raw[c].push_back(button[c]);
                n          = raw[c].size();
                s2         = raw[c][n-3];
                lvl_before = m_level[c];
                all_diff   = (n - 2 >= CM);
                for (int k = 0; k < CM; k++) begin
                    if (all_diff && raw[c][n-3-k] == m_level[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[c] = s2;
                    if (s2) e.prs[c] = 1'b1;
                    else    e.rls[c] = 1'b1;
                end
`ifdef DEBOUNCE_REPEAT_EN
                if (!lvl_before) begin
                    m_rc[c] = 0;
                end else if (s2) begin
                    m_rc[c]++;
                    if (m_rc[c] == RC) begin
                        e.prs[c] = 1'b1;
                        m_rc[c]  = 0;
                    end
                end
`endif
                if (raw[c].size() > CM + 4) void'(raw[c].pop_front());
                e.lvl[c] = m_level[c];
            end
            e.anyp     = m_prev_any;
            m_prev_any = |e.prs;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the queued prediction
    always @(posedge clock) begin
        obs_t e, a;
        #1;
        a = {level, press_pulse, release_pulse, any_press};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty t=%0t: got %b, required a queued prediction", $time, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t: got lvl=%b prs=%b rls=%b any=%b, required lvl=%b prs=%b rls=%b any=%b",
                         $time, a.lvl, a.prs, a.rls, a.anyp, e.lvl, e.prs, e.rls, e.anyp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        button  = '0;
        cyc(3);
        reset_n = 1'b1;
        cyc(3);
        // Single press on channel 0
        button = 4'b0001; cyc(12);
        button = 4'b0000; cyc(10);
        // Glitches shorter than the stable time on channel 1
        repeat (4) begin
            button = 4'b0010; cyc(3);
            button = 4'b0000; cyc(3);
        end
        cyc(6);
        // Press and release on channel 2
        button = 4'b0100; cyc(10);
        button = 4'b0000; cyc(10);
        // Simultaneous press on channels 1 and 3
        button = 4'b1010; cyc(10);
        button = 4'b0000; cyc(10);
        // Reset mid-count with channel 3 held
        button = 4'b1000; cyc(4);
        reset_n = 1'b0; cyc(3);
        reset_n = 1'b1; cyc(10);
        button = 4'b0000; cyc(10);
        // Long hold on channel 0 (auto-repeat when enabled)
        button = 4'b0001; cyc(30);
        button = 4'b0000; cyc(10);
        // Random toggling with occasional resets
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 4) == 0) button[c] = ~button[c];
            end
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0; cyc(2);
                reset_n = 1'b1;
            end
            cyc(1);
        end
        button = '0;
        cyc(15);
        @(posedge clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
